// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the time-multiplexed FIR controller.
package fir_ctrl_pkg;

    localparam int unsigned C_NUM_DEF   = 49;
    localparam int unsigned ADDR_W_DEF  = 6;
    localparam int unsigned MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRun,
        StDrain,
        StHold
    } state_e;

    // Address width must cover every tap and the drain counter needs at least one cycle.
    function automatic bit cfg_ok(int unsigned c_num, int unsigned addr_w, int unsigned mac_lat);
        return (c_num >= 1) && (addr_w >= 1) && (int'(addr_w) >= $clog2(c_num))
            && (mac_lat >= 1);
    endfunction

endpackage

// File: rtl/fir_ring_addr.sv
// Modulo-C_NUM ring arithmetic: base minus offset, and base plus one with wrap.
module fir_ring_addr
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM  = C_NUM_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] off_i,
    output logic [ADDR_W-1:0] diff_o,
    output logic [ADDR_W-1:0] next_o
);

    localparam logic [ADDR_W-1:0] ModC    = ADDR_W'(C_NUM);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(C_NUM - 1);
    localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);

    // The true result is always below C_NUM, so ADDR_W-bit wraparound arithmetic is exact.
    always_comb begin
        diff_o = (base_i >= off_i) ? (base_i - off_i) : (base_i - off_i + ModC);
        next_o = (base_i == LastIdx) ? '0 : (base_i + One);
    end

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Sequencer for a single-MAC time-multiplexed FIR: sample intake, circular buffer
// addressing, MAC strobes and result handshake.
module fir_tdm_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM   = C_NUM_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              smp_we_o,
    output logic              smp_wzero_o,
    output logic [ADDR_W-1:0] smp_waddr_o,
    output logic [ADDR_W-1:0] smp_raddr_o,
    output logic [ADDR_W-1:0] coef_raddr_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic              mac_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o
);

    localparam int unsigned       CntW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(C_NUM - 1);
    localparam logic [CntW-1:0]   DrainEnd = CntW'(MAC_LAT - 1);

    if (!cfg_ok(C_NUM, ADDR_W, MAC_LAT)) begin : g_cfg_err
        $error("fir_tdm_ctrl: invalid C_NUM / ADDR_W / MAC_LAT combination");
    end

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] tap_q;
    logic [CntW-1:0]   drain_q;
    logic              in_ready_q;
    logic              smp_wzero_q;
    logic [ADDR_W-1:0] smp_raddr_q;
    logic              mac_en_q;
    logic              mac_clr_q;
    logic              mac_last_q;
    logic              out_valid_q;
    logic              busy_q;

    logic              accept;
    logic [ADDR_W-1:0] tap_inc;
    logic [ADDR_W-1:0] ring_base;
    logic [ADDR_W-1:0] ring_diff;
    logic [ADDR_W-1:0] ring_next;

    // One ring unit: increments the write pointer in INIT/IDLE, walks the read address in RUN.
    always_comb begin
        accept    = in_valid_i & in_ready_q;
        tap_inc   = tap_q + ADDR_W'(1);
        ring_base = (state_q == StRun) ? head_q : wr_ptr_q;
    end

    fir_ring_addr #(
        .C_NUM  (C_NUM),
        .ADDR_W (ADDR_W)
    ) u_ring (
        .base_i (ring_base),
        .off_i  (tap_inc),
        .diff_o (ring_diff),
        .next_o (ring_next)
    );

    // Controller FSM with all control outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            wr_ptr_q    <= '0;
            head_q      <= '0;
            tap_q       <= '0;
            drain_q     <= '0;
            in_ready_q  <= 1'b0;
            smp_wzero_q <= 1'b1;
            smp_raddr_q <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                StInit: begin
                    // wr_ptr doubles as the zeroing address and wraps back to 0 at the end.
                    wr_ptr_q <= ring_next;
                    if (wr_ptr_q == LastIdx) begin
                        state_q     <= StIdle;
                        in_ready_q  <= 1'b1;
                        smp_wzero_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                StIdle: begin
                    if (accept) begin
                        state_q     <= StRun;
                        head_q      <= wr_ptr_q;
                        wr_ptr_q    <= ring_next;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        tap_q       <= '0;
                        smp_raddr_q <= wr_ptr_q;
                        mac_en_q    <= 1'b1;
                        mac_clr_q   <= 1'b1;
                        mac_last_q  <= (C_NUM == 1);
                    end
                end
                StRun: begin
                    if (tap_q == LastIdx) begin
                        state_q    <= StDrain;
                        drain_q    <= '0;
                        mac_en_q   <= 1'b0;
                        mac_clr_q  <= 1'b0;
                        mac_last_q <= 1'b0;
                    end else begin
                        tap_q       <= tap_inc;
                        smp_raddr_q <= ring_diff;
                        mac_clr_q   <= 1'b0;
                        mac_last_q  <= (tap_inc == LastIdx);
                    end
                end
                StDrain: begin
                    if (drain_q == DrainEnd) begin
                        state_q     <= StHold;
                        out_valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q + CntW'(1);
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    // Write strobe is the only combinational output: the datapath writes in the handshake cycle.
    always_comb begin
        smp_we_o     = accept | (state_q == StInit);
        in_ready_o   = in_ready_q;
        smp_wzero_o  = smp_wzero_q;
        smp_waddr_o  = wr_ptr_q;
        smp_raddr_o  = smp_raddr_q;
        coef_raddr_o = tap_q;
        mac_en_o     = mac_en_q;
        mac_clr_o    = mac_clr_q;
        mac_last_o   = mac_last_q;
        out_valid_o  = out_valid_q;
        busy_o       = busy_q;
    end

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// Bench for fir_tdm_ctrl: emulates the sample RAM, coefficient ROM and MAC around the
// controller and checks results against a direct convolution of the accepted samples.
module tb_fir_tdm_ctrl;

    localparam int C_NUM   = 49;
    localparam int ADDR_W  = 6;
    localparam int MAC_LAT = 2;
    localparam int PERIOD  = C_NUM + MAC_LAT + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              smp_we;
    logic              smp_wzero;
    logic [ADDR_W-1:0] smp_waddr;
    logic [ADDR_W-1:0] smp_raddr;
    logic [ADDR_W-1:0] coef_raddr;
    logic              mac_en;
    logic              mac_clr;
    logic              mac_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic signed [11:0] in_data;

    int n_tests = 0;
    int n_fail  = 0;

    int ram [C_NUM];
    int rom [C_NUM];
    bit ram_seeded = 1'b0;
    int rd_q, cf_q, acc;
    logic en_q, clr_q;
    int cyc = 0;
    int hist[$];

    always #5 clk = ~clk;

    fir_tdm_ctrl #(
        .C_NUM   (C_NUM),
        .ADDR_W  (ADDR_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .smp_we_o     (smp_we),
        .smp_wzero_o  (smp_wzero),
        .smp_waddr_o  (smp_waddr),
        .smp_raddr_o  (smp_raddr),
        .coef_raddr_o (coef_raddr),
        .mac_en_o     (mac_en),
        .mac_clr_o    (mac_clr),
        .mac_last_o   (mac_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy)
    );

    // External datapath: RAM with garbage power-up contents, 1-cycle reads, 1-cycle MAC.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_seeded) begin
            foreach (ram[i]) ram[i] <= int'($urandom_range(4095)) - 2048;
            ram_seeded <= 1'b1;
        end else if (smp_we) begin
            ram[smp_waddr] <= smp_wzero ? 0 : int'(in_data);
        end
        rd_q  <= ram[smp_raddr];
        cf_q  <= rom[coef_raddr];
        en_q  <= mac_en;
        clr_q <= mac_clr;
        if (en_q) acc <= clr_q ? rd_q * cf_q : acc + rd_q * cf_q;
        if (!rst_n) hist.delete();
        else if (in_valid && in_ready) hist.push_back(int'(in_data));
    end

    // y[n] = sum_k h[k] * x[n-k], with samples before the last reset taken as zero.
    function automatic int ref_y();
        int n = hist.size();
        int s = 0;
        for (int k = 0; k < C_NUM; k++) begin
            if (n - 1 - k >= 0) s += rom[k] * hist[n - 1 - k];
        end
        return s;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({in_ready, smp_wzero, mac_en, mac_clr, mac_last, out_valid, busy, smp_we}
            !== 8'b0100_0011) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 01000011",
                     {in_ready, smp_wzero, mac_en, mac_clr, mac_last, out_valid, busy, smp_we});
        end
        n_tests++;
        if ({smp_waddr, smp_raddr, coef_raddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got w=%0d r=%0d c=%0d, want 0 0 0",
                     smp_waddr, smp_raddr, coef_raddr);
        end
    endtask

    // Expects reset currently asserted; releases it and checks the zeroing pass.
    task automatic test_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < C_NUM; c++) begin
            #1;
            n_tests++;
            if ({smp_we, smp_wzero, in_ready, busy} !== 4'b1101 || smp_waddr !== ADDR_W'(c)) begin
                n_fail++;
                $display("FAIL init_write c=%0d: got we/wz/rdy/busy=%b waddr=%0d, want 1101 waddr=%0d",
                         c, {smp_we, smp_wzero, in_ready, busy}, smp_waddr, c);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if ({smp_we, smp_wzero, in_ready, busy, out_valid} !== 5'b00100 || smp_waddr !== '0) begin
            n_fail++;
            $display("FAIL init_done: got we/wz/rdy/busy/ov=%b waddr=%0d, want 00100 waddr=0",
                     {smp_we, smp_wzero, in_ready, busy, out_valid}, smp_waddr);
        end
    endtask

    task automatic test_single();
        int head;
        head = hist.size() % C_NUM;
        in_data  = 12'($urandom);
        in_valid = 1'b1;
        #1;
        n_tests++;
        if (smp_we !== 1'b1 || smp_waddr !== ADDR_W'(head) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: got we=%b waddr=%0d rdy=%b, want 1 %0d 1",
                     smp_we, smp_waddr, in_ready, head);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < C_NUM; k++) begin
            #1;
            n_tests++;
            if (smp_raddr !== ADDR_W'((head - k + C_NUM) % C_NUM) || coef_raddr !== ADDR_W'(k)
                || mac_en !== 1'b1 || mac_clr !== (k == 0) || mac_last !== (k == C_NUM - 1)
                || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_tap k=%0d: got r=%0d c=%0d en/clr/last=%b%b%b rdy=%b ov=%b, want r=%0d c=%0d",
                         k, smp_raddr, coef_raddr, mac_en, mac_clr, mac_last, in_ready, out_valid,
                         (head - k + C_NUM) % C_NUM, k);
            end
            @(negedge clk);
        end
        for (int d = 0; d < MAC_LAT; d++) begin
            #1;
            n_tests++;
            if (mac_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_drain d=%0d: got en=%b ov=%b busy=%b, want 0 0 1",
                         d, mac_en, out_valid, busy);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || acc !== ref_y()) begin
            n_fail++;
            $display("FAIL single_result: got ov=%b y=%0d, want ov=1 y=%0d", out_valid, acc, ref_y());
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got rdy=%b ov=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int head;
        head = hist.size() % C_NUM;
        in_data  = 12'($urandom);
        in_valid = 1'b1;
        #1;
        n_tests++;
        if (smp_we !== 1'b1 || smp_waddr !== ADDR_W'(head)) begin
            n_fail++;
            $display("FAIL bp_write: got we=%b waddr=%0d, want 1 %0d", smp_we, smp_waddr, head);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 4 * PERIOD && out_valid !== 1'b1; t++) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || acc !== ref_y()) begin
            n_fail++;
            $display("FAIL bp_result: got ov=%b y=%0d, want ov=1 y=%0d", out_valid, acc, ref_y());
        end
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(1));
            in_data  = 12'($urandom);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || smp_we !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold t=%0d: got ov=%b rdy=%b we=%b busy=%b, want 1 0 0 1",
                         t, out_valid, in_ready, smp_we, busy);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || smp_waddr !== ADDR_W'(head + 1)) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b ov=%b busy=%b waddr=%0d, want 1 0 0 %0d",
                     in_ready, out_valid, busy, smp_waddr, head + 1);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        in_data  = 12'($urandom);
        in_valid = 1'b1;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_tests++;
        if (coef_raddr !== ADDR_W'(20) || mac_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_tap: got c=%0d en=%b, want 20 1", coef_raddr, mac_en);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, smp_wzero, mac_en, mac_clr, mac_last, out_valid, busy, smp_we}
            !== 8'b0100_0011 || {smp_waddr, smp_raddr, coef_raddr} !== '0) begin
            n_fail++;
            $display("FAIL midrun_async: got flags=%b w=%0d r=%0d c=%0d, want 01000011 0 0 0",
                     {in_ready, smp_wzero, mac_en, mac_clr, mac_last, out_valid, busy, smp_we},
                     smp_waddr, smp_raddr, coef_raddr);
        end
        @(negedge clk);
        test_init();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int results = 0;
        int since = -1;
        int head = 0;
        int last_acc = 0;
        bit took;
        out_ready = 1'b1;
        in_data   = 12'($urandom);
        in_valid  = 1'b1;
        for (int t = 0; t < 60 * PERIOD && results < 50; t++) begin
            #1;
            took = 1'b0;
            if (since >= 0) since++;
            if (in_valid && in_ready) begin
                took = 1'b1;
                n_tests++;
                if (smp_we !== 1'b1 || smp_waddr !== ADDR_W'(sent % C_NUM)) begin
                    n_fail++;
                    $display("FAIL b2b_write n=%0d: got we=%b waddr=%0d, want 1 %0d",
                             sent, smp_we, smp_waddr, sent % C_NUM);
                end
                if (sent > 0) begin
                    n_tests++;
                    if (cyc - last_acc !== PERIOD) begin
                        n_fail++;
                        $display("FAIL b2b_period n=%0d: got %0d cycles, want %0d",
                                 sent, cyc - last_acc, PERIOD);
                    end
                end
                last_acc = cyc;
                head     = sent % C_NUM;
                since    = 0;
                sent++;
            end else if (since >= 1 && since <= C_NUM) begin
                n_tests++;
                if (mac_en !== 1'b1 || smp_raddr !== ADDR_W'((head - (since - 1) + C_NUM) % C_NUM)
                    || coef_raddr !== ADDR_W'(since - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_tap n=%0d k=%0d: got en=%b r=%0d c=%0d, want 1 %0d %0d",
                             sent - 1, since - 1, mac_en, smp_raddr, coef_raddr,
                             (head - (since - 1) + C_NUM) % C_NUM, since - 1);
                end
            end
            if (out_valid) begin
                n_tests++;
                if (acc !== ref_y()) begin
                    n_fail++;
                    $display("FAIL b2b_result n=%0d: got %0d, want %0d", results, acc, ref_y());
                end
                results++;
            end
            @(negedge clk);
            if (took) begin
                if (sent < 50) in_data = 12'($urandom);
                else in_valid = 1'b0;
            end
        end
        n_tests++;
        if (sent != 50 || results != 50) begin
            n_fail++;
            $display("FAIL b2b_timeout: got sent=%0d results=%0d, want 50 50", sent, results);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_random_golden();
        localparam int N = 25;
        int sent = 0;
        int results = 0;
        bit took;
        for (int t = 0; t < N * (PERIOD + 80) && results < N; t++) begin
            if (!in_valid && sent < N && $urandom_range(2) == 0) begin
                in_valid = 1'b1;
                in_data  = 12'($urandom);
                sent++;
            end
            out_ready = 1'($urandom_range(1));
            #1;
            took = 1'b0;
            if (in_valid && in_ready) begin
                took = 1'b1;
                n_tests++;
                if (smp_we !== 1'b1 || smp_waddr !== ADDR_W'(hist.size() % C_NUM)) begin
                    n_fail++;
                    $display("FAIL rnd_write: got we=%b waddr=%0d, want 1 %0d",
                             smp_we, smp_waddr, hist.size() % C_NUM);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (acc !== ref_y()) begin
                    n_fail++;
                    $display("FAIL rnd_result n=%0d: got %0d, want %0d", results, acc, ref_y());
                end
                results++;
            end
            if ((out_valid && in_ready) || (!mac_en && (mac_clr || mac_last))) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd_excl: got ov=%b rdy=%b en=%b clr=%b last=%b, want no overlap",
                         out_valid, in_ready, mac_en, mac_clr, mac_last);
            end
            @(negedge clk);
            if (took) in_valid = 1'b0;
        end
        n_tests++;
        if (results != N) begin
            n_fail++;
            $display("FAIL rnd_timeout: got %0d results, want %0d", results, N);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        foreach (rom[i]) rom[i] = int'($urandom_range(4095)) - 2048;
        test_reset();
        test_init();
        test_single();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_golden();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tdm_ctrl.md
Name: fir_tdm_ctrl

Overview:
- Sequencer for a time-multiplexed FIR built around one shared MAC, a C_NUM-deep sample RAM and a coefficient ROM.
- Accepts one input sample per valid/ready handshake and generates the sample-RAM write and read addresses and the coefficient address.
- Drives the MAC control strobes and presents each result with an out_valid/out_ready handshake.
- Owns the circular sample buffer pointer and the post-reset buffer zeroing.

Parameters:
- C_NUM, 49, number of taps.
- ADDR_W, 6, address width for the sample RAM and coefficient ROM; must satisfy 2**ADDR_W >= C_NUM.
- MAC_LAT, 2, cycles from address issue to the last accumulate being visible at the external accumulator output (RAM read latency plus MAC pipeline).

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  an input sample is offered.
- in_ready  output  1  controller can accept a sample; registered.
- smp_we  output  1  sample-RAM write enable; equals in_valid & in_ready, or 1 during INIT.
- smp_wzero  output  1  datapath writes 0 instead of the input sample; registered.
- smp_waddr  output  ADDR_W  sample-RAM write address; registered.
- smp_raddr  output  ADDR_W  sample-RAM read address; registered.
- coef_raddr  output  ADDR_W  coefficient-ROM read address; registered.
- mac_en  output  1  the current address pair is valid for accumulation; registered.
- mac_clr  output  1  first tap: accumulator loads the product instead of adding; registered.
- mac_last  output  1  last tap; registered.
- out_valid  output  1  accumulator output holds a complete result; registered.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  asserted in every state except IDLE; registered.

Behaviour:
- Reset values while reset=0: state=INIT, wr_ptr=0, head=0, tap=0, in_ready=0, smp_wzero=1, smp_waddr=0, smp_raddr=0, coef_raddr=0, mac_en=0, mac_clr=0, mac_last=0, out_valid=0, busy=1.
- INIT:
  - One write per cycle with smp_we=1, smp_wzero=1 and smp_waddr=0..C_NUM-1, taking C_NUM cycles.
  - Then wr_ptr=0, state goes to IDLE, in_ready=1, smp_wzero=0, busy=0.
- IDLE:
  - in_ready=1. A handshake at an edge writes the sample at smp_waddr=wr_ptr (the write data path is external and combinational to smp_we).
  - At the same edge: head<=wr_ptr; wr_ptr<=wr_ptr+1, wrapping from C_NUM-1 to 0; in_ready<=0; tap<=0; state goes to RUN.
- RUN, tap k=0..C_NUM-1, one tap per cycle:
  - smp_raddr = (head-k) mod C_NUM, computed as head-k if head>=k, else head-k+C_NUM.
  - coef_raddr=k, mac_en=1, mac_clr=(k==0), mac_last=(k==C_NUM-1).
  - After k=C_NUM-1, state goes to DRAIN.
- DRAIN:
  - mac_en=0; a counter runs for MAC_LAT cycles.
  - Then out_valid<=1 and state goes to HOLD.
- HOLD:
  - out_valid stays high until out_ready=1 at an edge.
  - At that edge: out_valid<=0, in_ready<=1, state goes to IDLE.
  - out_ready while out_valid=0 has no effect.
- Latency: handshake edge E0 → tap 0 issued in cycle E0+1 → out_valid high from cycle E0+C_NUM+MAC_LAT+1.
  - Minimum sample period is C_NUM+MAC_LAT+2 cycles with out_ready tied high.
- Boundary conditions:
  - in_valid while in_ready=0: ignored; no write, no pointer change. The source holds the sample until in_ready=1.
  - Pointer wrap: head=0 with k=1 gives smp_raddr=C_NUM-1; wr_ptr goes C_NUM-1 → 0.
  - Reset asserted mid-RUN, DRAIN or HOLD: all state returns to reset values immediately (async); the result in flight is discarded; INIT re-zeroes the buffer after release.
  - Reset release is synchronized to clock by the system; no internal synchronizer.
  - mac_en, mac_clr and mac_last are never asserted outside RUN; mac_clr and mac_last coincide only if C_NUM=1.

Decomposition:
- Package fir_ctrl_pkg:
  - state enum {INIT, IDLE, RUN, DRAIN, HOLD};
  - default C_NUM, ADDR_W and MAC_LAT constants;
  - function clog2-based width check.
- One sub-module, fir_ring_addr (combinational modulo-C_NUM subtract and increment-with-wrap), shared by the write-pointer and read-address logic.

Test Plan:
- Reset release → smp_we=1 with smp_wzero=1 for exactly 49 cycles, addresses 0..48; in_ready rises in cycle 50; busy falls together with in_ready.
- One sample accepted at E0 with wr_ptr=0 → smp_waddr=0; cycles E0+1..E0+49 show smp_raddr 0,48,47,...,1 and coef_raddr 0..48; mac_clr only at E0+1, mac_last only at E0+49; out_valid at E0+52.
- 50 back-to-back samples with out_ready=1 → wr_ptr wraps 48→0; 50th sample written at addr 0, head=0, its reads run 0,48,...,1; each period is exactly 53 cycles.
- out_ready held 0 for 10 cycles after out_valid → out_valid stays 1, in_ready stays 0, and in_valid pulses meanwhile cause no write; releasing out_ready → IDLE on the next edge.
- reset pulled low at tap 20 of RUN → all outputs take reset values asynchronously; after release INIT repeats 49 zero writes and wr_ptr restarts at 0.
- Golden-model comparison: random 12-bit samples with random in_valid/out_ready gaps through an external MAC model → results match a reference 49-tap convolution bit-exactly.
